// File: rtl/retire_rob.sv
// Reorder buffer with in-order retire; releases each retired entry's old_pd to rename.
// Build option: define RETIRE_DUAL_EN to allow two retires per cycle (default: one).
module retire_rob #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_flag_i,
    input  logic [4:0]               rd_1,
    input  logic [4:0]               rd_2,
    input  logic [PREG_W-1:0]        pd_1,
    input  logic [PREG_W-1:0]        pd_2,
    input  logic [PREG_W-1:0]        old_pd_1,
    input  logic [PREG_W-1:0]        old_pd_2,
    output logic                     rob_full,
    output logic                     rob_empty,
    output logic [$clog2(DEPTH)-1:0] rob_tag_1,
    output logic [$clog2(DEPTH)-1:0] rob_tag_2,
    input  logic                     cmp_valid_1,
    input  logic                     cmp_valid_2,
    input  logic [$clog2(DEPTH)-1:0] cmp_tag_1,
    input  logic [$clog2(DEPTH)-1:0] cmp_tag_2,
    output logic                     rt_flag_1,
    output logic                     rt_flag_2,
    output logic [PREG_W-1:0]        fp_i_1,
    output logic [PREG_W-1:0]        fp_i_2,
    output logic [1:0]               rt_count
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W-1:0]  tail_b;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  done;
    logic [DEPTH-1:0]  has_dest;
    logic [PREG_W-1:0] pd_mem     [DEPTH];
    logic [PREG_W-1:0] old_pd_mem [DEPTH];

    logic       dispatch;
    logic       ret_a;
    logic       ret_b;
    logic [1:0] n_ret;

    // pd is kept per entry for debug visibility; nothing downstream consumes it.
    logic unused_pd;
    assign unused_pd = ^pd_mem[head];

    assign tail_b    = tail + TAG_W'(1);
    assign rob_full  = count > CNT_W'(DEPTH - 2);
    assign rob_empty = (count == '0);
    assign rob_tag_1 = tail;
    assign rob_tag_2 = tail_b;
    assign dispatch  = en_flag_i & ~rob_full;
    assign ret_a     = valid[head] & done[head];

`ifdef RETIRE_DUAL_EN
    logic [TAG_W-1:0] head_b;
    assign head_b = head + TAG_W'(1);
    assign ret_b  = ret_a & valid[head_b] & done[head_b];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rt_flag_2 <= 1'b0;
            fp_i_2    <= '0;
        end else begin
            rt_flag_2 <= ret_b & has_dest[head_b];
            if (ret_b && has_dest[head_b])
                fp_i_2 <= old_pd_mem[head_b];
        end
    end
`else
    assign ret_b     = 1'b0;
    assign rt_flag_2 = 1'b0;
    assign fp_i_2    = '0;
`endif

    assign n_ret = {1'b0, ret_a} + {1'b0, ret_b};

    // Retire clears are written last so they win over a completion to the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            valid     <= '0;
            done      <= '0;
            rt_flag_1 <= 1'b0;
            fp_i_1    <= '0;
            rt_count  <= '0;
        end else begin
            if (cmp_valid_1 && valid[cmp_tag_1])
                done[cmp_tag_1] <= 1'b1;
            if (cmp_valid_2 && valid[cmp_tag_2])
                done[cmp_tag_2] <= 1'b1;
            if (dispatch) begin
                valid[tail]   <= 1'b1;
                done[tail]    <= 1'b0;
                valid[tail_b] <= 1'b1;
                done[tail_b]  <= 1'b0;
                tail          <= tail + TAG_W'(2);
            end
            if (ret_a) begin
                valid[head] <= 1'b0;
                done[head]  <= 1'b0;
            end
            if (ret_b) begin
                valid[head + TAG_W'(1)] <= 1'b0;
                done[head + TAG_W'(1)]  <= 1'b0;
            end
            head      <= head + TAG_W'(n_ret);
            count     <= count + CNT_W'(dispatch ? 2 : 0) - CNT_W'(n_ret);
            rt_count  <= n_ret;
            rt_flag_1 <= ret_a & has_dest[head];
            if (ret_a && has_dest[head])
                fp_i_1 <= old_pd_mem[head];
        end
    end

    // Payload fields only matter while valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (dispatch) begin
            has_dest[tail]     <= (rd_1 != 5'd0);
            pd_mem[tail]       <= pd_1;
            old_pd_mem[tail]   <= old_pd_1;
            has_dest[tail_b]   <= (rd_2 != 5'd0);
            pd_mem[tail_b]     <= pd_2;
            old_pd_mem[tail_b] <= old_pd_2;
        end
    end
endmodule

// File: tb/tb_retire_rob.sv
// Randomized self-checking bench for retire_rob against an in-order queue model.
module tb_retire_rob;
    localparam int DEPTH  = 16;
    localparam int PREG_W = 6;
    localparam int TAG_W  = 4;
`ifdef RETIRE_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en_flag_i = 1'b0;
    logic [4:0]        rd_1 = '0, rd_2 = '0;
    logic [PREG_W-1:0] pd_1 = '0, pd_2 = '0, old_pd_1 = '0, old_pd_2 = '0;
    logic              rob_full, rob_empty;
    logic [TAG_W-1:0]  rob_tag_1, rob_tag_2;
    logic              cmp_valid_1 = 1'b0, cmp_valid_2 = 1'b0;
    logic [TAG_W-1:0]  cmp_tag_1 = '0, cmp_tag_2 = '0;
    logic              rt_flag_1, rt_flag_2;
    logic [PREG_W-1:0] fp_i_1, fp_i_2;
    logic [1:0]        rt_count;

    retire_rob #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
        .clk(clk), .rst_n(rst_n), .en_flag_i(en_flag_i),
        .rd_1(rd_1), .rd_2(rd_2), .pd_1(pd_1), .pd_2(pd_2),
        .old_pd_1(old_pd_1), .old_pd_2(old_pd_2),
        .rob_full(rob_full), .rob_empty(rob_empty),
        .rob_tag_1(rob_tag_1), .rob_tag_2(rob_tag_2),
        .cmp_valid_1(cmp_valid_1), .cmp_valid_2(cmp_valid_2),
        .cmp_tag_1(cmp_tag_1), .cmp_tag_2(cmp_tag_2),
        .rt_flag_1(rt_flag_1), .rt_flag_2(rt_flag_2),
        .fp_i_1(fp_i_1), .fp_i_2(fp_i_2), .rt_count(rt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        bit hd;
        int opd;
        bit done;
    } ent_t;

    ent_t q[$];
    int   tail_m;
    int   exp_fp1, exp_fp2;
    int   checks = 0;
    int   failures = 0;

    task automatic drive(input bit en, input int r1, input int o1, input int r2, input int o2);
        en_flag_i = en;
        rd_1 = 5'(r1);
        rd_2 = 5'(r2);
        old_pd_1 = PREG_W'(o1);
        old_pd_2 = PREG_W'(o2);
        pd_1 = PREG_W'($urandom);
        pd_2 = PREG_W'($urandom);
    endtask

    task automatic cmp(input bit v1, input int t1, input bit v2, input int t2);
        cmp_valid_1 = v1;
        cmp_tag_1 = TAG_W'(t1);
        cmp_valid_2 = v2;
        cmp_tag_2 = TAG_W'(t2);
    endtask

    task automatic idle_inputs();
        drive(1'b0, 0, 0, 0, 0);
        cmp(1'b0, 0, 1'b0, 0);
    endtask

    // One clock: check combinational status, advance the model, check registered outputs.
    task automatic step();
        bit full, ra, rb, ef1, ef2;
        int ecnt;
        #1;
        full = (q.size() > DEPTH - 2);
        checks++;
        if (rob_full !== full) begin
            failures++;
            $display("FAIL rob_full got=%0b exp=%0b", rob_full, full);
        end
        checks++;
        if (rob_empty !== (q.size() == 0)) begin
            failures++;
            $display("FAIL rob_empty got=%0b exp=%0b", rob_empty, q.size() == 0);
        end
        checks++;
        if (rob_tag_1 !== TAG_W'(tail_m) || rob_tag_2 !== TAG_W'((tail_m + 1) % DEPTH)) begin
            failures++;
            $display("FAIL rob_tag got=%0d,%0d exp=%0d,%0d", rob_tag_1, rob_tag_2,
                     tail_m, (tail_m + 1) % DEPTH);
        end
        ra = (q.size() > 0) && q[0].done;
        rb = DUAL && ra && (q.size() > 1) && q[1].done;
        ef1 = ra && q[0].hd;
        ef2 = rb && q[1].hd;
        if (ef1) exp_fp1 = q[0].opd;
        if (ef2) exp_fp2 = q[1].opd;
        ecnt = int'(ra) + int'(rb);
        foreach (q[i]) begin
            if (cmp_valid_1 && q[i].tag == int'(cmp_tag_1)) q[i].done = 1'b1;
            if (cmp_valid_2 && q[i].tag == int'(cmp_tag_2)) q[i].done = 1'b1;
        end
        if (ra) void'(q.pop_front());
        if (rb) void'(q.pop_front());
        if (en_flag_i && !full) begin
            q.push_back('{tag: tail_m, hd: (rd_1 != 0), opd: int'(old_pd_1), done: 1'b0});
            q.push_back('{tag: (tail_m + 1) % DEPTH, hd: (rd_2 != 0), opd: int'(old_pd_2), done: 1'b0});
            tail_m = (tail_m + 2) % DEPTH;
        end
        @(posedge clk);
        #1;
        checks++;
        if (rt_flag_1 !== ef1 || rt_flag_2 !== ef2) begin
            failures++;
            $display("FAIL rt_flag got=%0b,%0b exp=%0b,%0b", rt_flag_1, rt_flag_2, ef1, ef2);
        end
        checks++;
        if (fp_i_1 !== PREG_W'(exp_fp1) || fp_i_2 !== PREG_W'(exp_fp2)) begin
            failures++;
            $display("FAIL fp_i got=%0d,%0d exp=%0d,%0d", fp_i_1, fp_i_2, exp_fp1, exp_fp2);
        end
        checks++;
        if (rt_count !== 2'(ecnt)) begin
            failures++;
            $display("FAIL rt_count got=%0d exp=%0d", rt_count, ecnt);
        end
    endtask

    task automatic model_reset();
        q.delete();
        tail_m = 0;
        exp_fp1 = 0;
        exp_fp2 = 0;
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (rt_flag_1 !== 1'b0 || rt_flag_2 !== 1'b0 || fp_i_1 !== '0 || fp_i_2 !== '0 ||
            rt_count !== 2'd0 || rob_full !== 1'b0 || rob_empty !== 1'b1 ||
            rob_tag_1 !== 4'd0 || rob_tag_2 !== 4'd1) begin
            failures++;
            $display("FAIL %s got flags=%0b%0b fp=%0d,%0d cnt=%0d full=%0b empty=%0b tags=%0d,%0d exp 00 0,0 0 0 1 0,1",
                     name, rt_flag_1, rt_flag_2, fp_i_1, fp_i_2, rt_count, rob_full, rob_empty,
                     rob_tag_1, rob_tag_2);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_dual_complete();
        int t;
        t = tail_m;
        drive(1'b1, 5, 5, 6, 6);
        step();
        idle_inputs();
        cmp(1'b1, t, 1'b1, (t + 1) % DEPTH);
        step();
        idle_inputs();
        repeat (3) step();
    endtask

    task automatic test_out_of_order();
        int t;
        t = tail_m;
        drive(1'b1, 5, 5, 6, 6);
        step();
        idle_inputs();
        cmp(1'b1, (t + 1) % DEPTH, 1'b0, 0);
        step();
        idle_inputs();
        step();
        cmp(1'b1, t, 1'b1, t);
        step();
        idle_inputs();
        repeat (3) step();
    endtask

    task automatic test_no_dest();
        int t;
        t = tail_m;
        drive(1'b1, 0, 9, 7, 7);
        step();
        idle_inputs();
        cmp(1'b1, t, 1'b1, (t + 1) % DEPTH);
        step();
        idle_inputs();
        repeat (3) step();
    endtask

    task automatic test_fill_wrap();
        int t0, idx;
        t0 = tail_m;
        for (int p = 0; p < 8; p++) begin
            drive(1'b1, 1 + p, 10 + 2 * p, 20 + p, 11 + 2 * p);
            step();
        end
        drive(1'b1, 3, 63, 4, 62);
        step();
        idle_inputs();
        checks++;
        if (rob_tag_1 !== TAG_W'(t0) || rob_full !== 1'b1) begin
            failures++;
            $display("FAIL fill_ignore got tag=%0d full=%0b exp tag=%0d full=1", rob_tag_1, rob_full, t0);
        end
        idx = t0;
        for (int k = 0; k < 8; k++) begin
            cmp(1'b1, idx, 1'b1, (idx + 1) % DEPTH);
            idx = (idx + 2) % DEPTH;
            step();
        end
        idle_inputs();
        repeat (DEPTH + 2) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            int t1, t2;
            drive(($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31), $urandom_range(0, 63),
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31), $urandom_range(0, 63));
            t1 = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)].tag : $urandom_range(0, DEPTH - 1);
            t2 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, DEPTH - 1) :
                 ((q.size() > 0) ? q[$urandom_range(0, q.size() - 1)].tag : 0);
            cmp(($urandom_range(0, 1) == 1), t1, ($urandom_range(0, 2) == 0), t2);
            step();
        end
        idle_inputs();
        for (int c = 0; c < 3 * DEPTH && q.size() > 0; c++) begin
            cmp(1'b1, q[0].tag, q.size() > 1, (q.size() > 1) ? q[1].tag : 0);
            step();
        end
        idle_inputs();
        repeat (3) step();
        checks++;
        if (rob_empty !== 1'b1) begin
            failures++;
            $display("FAIL drain_empty got=%0b exp=1", rob_empty);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        t = tail_m;
        drive(1'b1, 8, 40, 9, 41);
        step();
        drive(1'b1, 10, 42, 11, 43);
        step();
        idle_inputs();
        cmp(1'b1, t, 1'b1, (t + 1) % DEPTH);
        @(posedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("reset_mid");
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step();
    endtask

    initial begin
        test_reset();
        test_dual_complete();
        test_out_of_order();
        test_no_dest();
        test_fill_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
